// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequences the shared multiply/divide resource for the E stage.
// Holds HI/LO, latches the arithmetic result when an md op is accepted, and
// releases it to HI/LO after a fixed latency so dependent D-stage users stall.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; MULT/DIV ops are accepted, MTHI/MTLO write immediately
// BUSY  | result latched, counting down the fixed latency; starts ignored
module md_unit_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        xstall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        res_wr_q, res_wr_d;

    logic [63:0] mul_a, mul_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Result datapath: one 64-bit multiply serves both signednesses via the
    // operand extension; divide works on magnitudes so the most-negative
    // dividend over -1 wraps cleanly to 0x80000000 with remainder 0.
    always_comb begin
        mul_a = {{32{(op == OP_MULT) & a[31]}}, a};
        mul_b = {{32{(op == OP_MULT) & b[31]}}, b};
        prod  = mul_a * mul_b;
        a_neg = (op == OP_DIV) & a[31];
        b_neg = (op == OP_DIV) & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = (b == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b) : b);
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            res_hi_d = prod[63:32];
                            res_lo_d = prod[31:0];
                            res_wr_d = 1'b1;
                            cnt_d    = 5'(MUL_CYCLES);
                            state_d  = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_hi_d = rem;
                            res_lo_d = quo;
                            // divide by zero still burns the latency but leaves HI/LO alone
                            res_wr_d = (b != 32'd0);
                            cnt_d    = 5'(DIV_CYCLES);
                            state_d  = BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; reset abandons any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    // Outputs: busy is registered; xstall also covers the issuing cycle.
    always_comb begin
        hi     = hi_q;
        lo     = lo_q;
        busy   = (state_q == BUSY);
        xstall = busy | (start & (op <= OP_DIVU));
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed and random md operations checked against a
// plain-arithmetic HI/LO model.
module tb_md_unit_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, xstall;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_unit_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .xstall(xstall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int latency(input logic [2:0] o);
        if (o <= 3'd1) return MUL_N;
        if (o <= 3'd3) return DIV_N;
        return 0;
    endfunction

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          p, q, r;
        longint unsigned pu;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                pu = longint'({32'd0, x}) * longint'({32'd0, y});
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd2: if (y != 32'd0) begin
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd3: if (y != 32'd0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic do_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        int n;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk({tag, " busy_at_start"}, {31'd0, busy}, 32'd0);
        chk({tag, " xstall_start"}, {31'd0, xstall}, {31'd0, (o <= 3'd3)});
        tick();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        #1;
        if (o <= 3'd3) chk({tag, " xstall_busy"}, {31'd0, xstall}, 32'd1);
        model(o, x, y);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk({tag, " busy_cycles"}, 32'(n), 32'(latency(o)));
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
    endtask

    initial begin
        int n, late;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) tick();
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset xstall", {31'd0, xstall}, 32'd0);
        start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd3;
        tick();
        chk("reset dominates start", {31'd0, busy}, 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();

        do_md(3'd0, 32'hFFFFFFFE, 32'd3, "mult");
        chk("mult hi const", hi, 32'hFFFFFFFF);
        chk("mult lo const", lo, 32'hFFFFFFFA);
        do_md(3'd1, 32'hFFFFFFFF, 32'd2, "multu");
        chk("multu hi const", hi, 32'd1);
        chk("multu lo const", lo, 32'hFFFFFFFE);
        do_md(3'd2, 32'hFFFFFFF9, 32'd2, "div neg");
        chk("div lo const", lo, 32'hFFFFFFFD);
        chk("div hi const", hi, 32'hFFFFFFFF);
        do_md(3'd2, 32'h80000000, 32'hFFFFFFFF, "div ovf");
        chk("div ovf lo const", lo, 32'h80000000);
        chk("div ovf hi const", hi, 32'd0);
        do_md(3'd4, 32'h11, 32'd0, "mthi");
        do_md(3'd5, 32'h22, 32'd0, "mtlo");
        do_md(3'd3, 32'h12345678, 32'd0, "divu by0");
        chk("divu by0 hi const", hi, 32'h11);
        chk("divu by0 lo const", lo, 32'h22);
        do_md(3'd4, 32'hDEADBEEF, 32'd0, "mthi beef");
        do_md(3'd6, 32'hCAFEF00D, 32'd1, "noop6");
        do_md(3'd7, 32'hCAFEF00D, 32'd1, "noop7");

        // MTLO issued while busy must be ignored
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6;
        tick();
        start = 1'b0;
        tick();
        $display("note: protocol violation injected (MTLO while busy)");
        start = 1'b1; op = 3'd5; a = 32'd5;
        #1;
        chk("mtlo_busy xstall", {31'd0, xstall}, 32'd1);
        tick();
        start = 1'b0;
        model(3'd0, 32'd7, 32'd6);
        n = 2;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("mtlo_busy busy_cycles", 32'(n), 32'(MUL_N));
        chk("mtlo_busy lo", lo, 32'd42);
        chk("mtlo_busy hi", hi, m_hi);

        // reset during the 4th busy cycle of a divide
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("midreset busy before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        late = 0;
        repeat (12) begin
            tick();
            if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) late++;
        end
        chk("midreset late write", 32'(late), 32'd0);

        // back-to-back: MULT in the first idle cycle after a DIV
        do_md(3'd2, 32'd1000, 32'd33, "b2b div");
        do_md(3'd0, 32'hFFFF0000, 32'h00010001, "b2b mult");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 4) == 0) rx = 32'h80000000;
            if ($urandom_range(0, 4) == 0) ry = 32'hFFFFFFFF;
            do_md(ro, rx, ry, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
